// File: rtl/sram_arbiter.sv
// Single-port 512Kx8 SRAM sequencer shared by the CPU strobes and the loader; CPU wins ties.
// Access takes ACCESS_CYCLES+2 clocks (ACC phase, DONE hold, IDLE); the loader holds ldReq until ldAck.
module sram_arbiter #(
  parameter int ACCESS_CYCLES = 2
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        cpuRd,
  input  logic        cpuWr,
  input  logic [18:0] cpuA,
  input  logic [7:0]  cpuD,
  output logic [7:0]  cpuQ,
  input  logic        ldReq,
  input  logic        ldWr,
  input  logic [18:0] ldA,
  input  logic [7:0]  ldD,
  output logic [7:0]  ldQ,
  output logic        ldAck,
  output logic [18:0] sramA,
  output logic [7:0]  sramDo,
  input  logic [7:0]  sramDi,
  output logic        sramDoe,
  output logic        sramOe,
  output logic        sramWe
);

  typedef enum logic [1:0] {IDLE, ACC, DONE} state_t;

  localparam logic [3:0] ACC_LAST = 4'(ACCESS_CYCLES);

  state_t      state, state_nx;
  logic        owner_ld;
  logic        dir_wr;
  logic [3:0]  cnt;
  logic        prev_rd, prev_wr;
  logic        cpu_pend, cpu_pend_wr;
  logic [18:0] cpu_addr;
  logic [7:0]  cpu_data;

  logic        rd_edge, wr_edge, cpu_req;
  logic        grant_cpu, grant_ld, acc_last;
  logic        acc_wr;
  logic [18:0] acc_addr;
  logic [7:0]  acc_data;

  always_comb begin
    rd_edge   = cpuRd & ~prev_rd;
    wr_edge   = cpuWr & ~prev_wr;
    cpu_req   = cpu_pend | rd_edge | wr_edge;
    acc_last  = (cnt == ACC_LAST);
    grant_cpu = 1'b0;
    grant_ld  = 1'b0;
    state_nx  = state;
    case (state)
      IDLE: begin
        if (cpu_req) begin
          grant_cpu = 1'b1;
          state_nx  = ACC;
        end else if (ldReq) begin
          grant_ld = 1'b1;
          state_nx = ACC;
        end
      end
      ACC:     if (acc_last) state_nx = DONE;
      DONE:    state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  // A fresh edge in IDLE is served straight from the live bus; otherwise the latched copy.
  always_comb begin
    acc_wr   = ldWr;
    acc_addr = ldA;
    acc_data = ldD;
    if (grant_cpu) begin
      acc_wr   = cpu_pend ? cpu_pend_wr : wr_edge;
      acc_addr = cpu_pend ? cpu_addr    : cpuA;
      acc_data = cpu_pend ? cpu_data    : cpuD;
    end
  end

  always_ff @(posedge clock) begin
    if (!reset) state <= IDLE;
    else        state <= state_nx;
  end

  always_ff @(posedge clock) begin
    if (!reset) begin
      prev_rd     <= 1'b1;
      prev_wr     <= 1'b1;
      cpu_pend    <= 1'b0;
      cpu_pend_wr <= 1'b0;
      cpu_addr    <= '0;
      cpu_data    <= '0;
      owner_ld    <= 1'b0;
      dir_wr      <= 1'b0;
      cnt         <= '0;
      sramA       <= '0;
      sramDo      <= '0;
      sramDoe     <= 1'b0;
      sramOe      <= 1'b1;
      sramWe      <= 1'b1;
      cpuQ        <= 8'hFF;
      ldQ         <= '0;
      ldAck       <= 1'b0;
    end else begin
      prev_rd <= cpuRd;
      prev_wr <= cpuWr;
      ldAck   <= 1'b0;

      if (grant_cpu) begin
        cpu_pend <= 1'b0;
      end else if ((rd_edge | wr_edge) && !cpu_pend) begin
        cpu_pend    <= 1'b1;
        cpu_pend_wr <= wr_edge;
        cpu_addr    <= cpuA;
        cpu_data    <= cpuD;
      end

      case (state)
        IDLE: begin
          if (grant_cpu || grant_ld) begin
            owner_ld <= grant_ld;
            dir_wr   <= acc_wr;
            sramA    <= acc_addr;
            sramDo   <= acc_data;
            sramDoe  <= acc_wr;
            sramOe   <= acc_wr;
            sramWe   <= 1'b1;
            cnt      <= 4'd1;
          end
        end
        ACC: begin
          cnt <= cnt + 4'd1;
          if (acc_last) begin
            sramOe <= 1'b1;
            sramWe <= 1'b1;
            ldAck  <= owner_ld;
            if (!dir_wr) begin
              if (owner_ld) ldQ  <= sramDi;
              else          cpuQ <= sramDi;
            end
          end else if (dir_wr) begin
            // First ACC cycle is address setup; WE drops for the remaining ones.
            sramWe <= 1'b0;
          end
        end
        DONE:    sramDoe <= 1'b0;
        default: ;
      endcase
    end
  end

endmodule

// File: doc/sram_arbiter.md
# sram_arbiter

Single-port controller for the external 512K×8 SRAM behind the memory mapper. It shares the SRAM between the CPU port, which carries the already-decoded memRd/memWr/memA strobes, and a loader port used to fill ROM/esxDOS images and to read back memory. It sequences each access into SRAM address, OE, WE and data-drive phases. The system clock runs much faster than the CPU, so both requesters fit between CPU bus cycles.

## Interface
- ACCESS_CYCLES, 2, cycles from address valid to data latch on read, and length of the write pulse window; legal range 2..15.
- clock  in  1  system clock; all logic is on the rising edge.
- reset  in  1  synchronous, active-low reset.
- cpuRd  in  1  CPU read strobe, active-high level (memRd); held for many clocks.
- cpuWr  in  1  CPU write strobe, active-high level (memWr); held for many clocks.
- cpuA  in  19  CPU physical address (memA).
- cpuD  in  8  CPU write data.
- cpuQ  out  8  latched CPU read data.
- ldReq  in  1  loader request level; held until ldAck.
- ldWr  in  1  loader direction: 1 = write, 0 = read; sampled at grant.
- ldA  in  19  loader address.
- ldD  in  8  loader write data.
- ldQ  out  8  loader read data; valid with ldAck.
- ldAck  out  1  one-cycle completion pulse.
- sramA  out  19  SRAM address.
- sramDo  out  8  data to SRAM.
- sramDi  in  8  data from SRAM.
- sramDoe  out  1  data bus drive enable (1 = drive sramDo).
- sramOe  out  1  SRAM output enable, active-low.
- sramWe  out  1  SRAM write enable, active-low.

## Operation
- States: IDLE, ACC, DONE. The grant owner is a 1-bit register (CPU or loader). The direction is a 1-bit register.
- CPU request detection: a rising edge of cpuRd or of cpuWr, registered as a pending flag. The previous-strobe registers reset to 1, so a strobe already high at reset release never triggers an access.
- Pending CPU flags latch cpuA and cpuD at the edge cycle. They clear when the CPU access is granted.
- IDLE: a pending CPU request wins. Otherwise ldReq is granted. Otherwise the block stays in IDLE. If both are present in the same cycle, the CPU wins and the loader waits without losing its request.
- ACC, read: sramA = address, sramOe = 0, sramDoe = 0 for ACCESS_CYCLES cycles. On the last ACC cycle, sramDi is captured into cpuQ or ldQ.
- ACC, write: sramA, sramDo and sramDoe = 1 are valid from the first ACC cycle. sramWe = 1 in the first ACC cycle (address setup) and sramWe = 0 in ACC cycles 2..ACCESS_CYCLES.
- DONE: lasts one cycle. sramWe = 1 and sramOe = 1. Address and data are held and sramDoe stays at its ACC value (hold time). For a loader grant, ldAck = 1 in this cycle. The next state is IDLE.
- The access counter is 4 bits, loaded with 1 on entry to ACC. It increments each ACC cycle, and ACC exits when the counter equals ACCESS_CYCLES.
- In IDLE: sramOe = 1, sramWe = 1, sramDoe = 0, and sramA holds its last value.
- cpuQ changes only on the capture cycle of a CPU read. ldQ changes only on the capture cycle of a loader read.

## Timing
- Reset values: state IDLE, sramA = 0, sramDo = 0, sramDoe = 0, sramOe = 1, sramWe = 1, cpuQ = 8'hFF, ldQ = 0, ldAck = 0, pending flags 0.
- Reset asserted mid-access: at the next edge the block returns to IDLE with all outputs at their reset values. An in-flight write may be truncated. No ldAck is issued.
- CPU edge sampled at cycle N: the pending flag is set at N+1. If IDLE, ACC runs N+1..N+ACCESS_CYCLES, cpuQ is valid at N+ACCESS_CYCLES+1, and DONE is at N+ACCESS_CYCLES+1.
- Worst-case CPU latency is a loader access already in ACC: 2·(ACCESS_CYCLES+1)+1 clocks. The system clock/CPU ratio must keep this below the CPU read-sample point.
- Loader: from ldReq granted in IDLE, ldAck is asserted ACCESS_CYCLES+1 cycles later. The loader must drop ldReq, or present the next request, in the cycle after ldAck. ldReq still high at IDLE is treated as a new request.
- Back-to-back: DONE→IDLE→ACC. There is a minimum of ACCESS_CYCLES+2 cycles per access.

## Test plan
- Reset, then idle: sramOe = 1, sramWe = 1, sramDoe = 0, cpuQ = FF. A strobe held high through reset release produces no access.
- CPU read, cpuA = 19'h2ABCD, SRAM model returns 8'h5A, ACCESS_CYCLES = 2: sramOe is low for exactly 2 cycles, and cpuQ = 5A three cycles after the edge.
- CPU write, cpuA = 19'h14000, cpuD = 8'hC3: sramWe is low for 1 cycle (ACCESS_CYCLES = 2). Address and data are stable for the setup, WE-low and hold cycles. The model memory contains C3.
- Loader streams 16 writes to 19'h00000..0000F with data = address. Exactly 16 ldAck pulses occur and a read-back through the loader matches.
- CPU edge and ldReq in the same cycle: the CPU access completes first. The loader access follows with no gap beyond IDLE, and its ldAck arrives 2·(ACCESS_CYCLES+1)+1 cycles later.
- Reset asserted during the second ACC cycle of a loader write: sramWe = 1 and sramDoe = 0 at the next edge, and there is no ldAck. A loader request re-issued after reset completes normally.
